// File: rtl/mul_div_control_sequencer_pkg.sv
// Shared definitions for the MUL/DIV control sequencer: state encoding,
// opcode constants and instruction-register field positions.
package mul_div_control_sequencer_pkg;

    typedef enum logic [3:0] {
        IDLE,
        T0,
        T1,
        T2,
        DEC,
        T3,
        T4,
        T5,
        T6,
        DONE
    } state_t;

    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    localparam int NUM_REGS  = 16;
    localparam int REG_IDX_W = 4;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 22;
    localparam int RA_LSB  = 19;
    localparam int RB_MSB  = 18;
    localparam int RB_LSB  = 15;

    typedef struct packed {
        logic [4:0]           opc;
        logic [REG_IDX_W-1:0] ra;
        logic [REG_IDX_W-1:0] rb;
    } ir_fields_t;

    function automatic ir_fields_t decode_ir(input logic [31:0] ir);
        ir_fields_t f;
        f.opc = ir[OPC_MSB:OPC_LSB];
        f.ra  = ir[RA_MSB:RA_LSB];
        f.rb  = ir[RB_MSB:RB_LSB];
        return f;
    endfunction

    function automatic logic is_mul_div(input logic [4:0] opc);
        return (opc == OP_MUL) || (opc == OP_DIV);
    endfunction

endpackage

// File: rtl/mul_div_control_sequencer_if.sv
// Run-control handshake, memory handshake, IR input and DataPath control strobes.
// The master modport is the sequencer; the slave modport is run logic plus DataPath.
interface mul_div_control_sequencer_if;

    logic        start;
    logic        mem_ready;
    logic [31:0] ir_value;

    logic        busy;
    logic        done;
    logic        error;

    logic        PCout;
    logic        IncPC;
    logic        MARin;
    logic        Zin;
    logic        Zlo_out;
    logic        Zhi_out;
    logic        PCin;
    logic        Read;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Yin;
    logic        LOin;
    logic        HIin;
    logic [15:0] Rout;
    logic [4:0]  alu_op;

    modport master (
        input  start, mem_ready, ir_value,
        output busy, done, error,
        output PCout, IncPC, MARin, Zin, Zlo_out, Zhi_out, PCin, Read,
        output MDRin, MDRout, IRin, Yin, LOin, HIin, Rout, alu_op
    );

    modport slave (
        output start, mem_ready, ir_value,
        input  busy, done, error,
        input  PCout, IncPC, MARin, Zin, Zlo_out, Zhi_out, PCin, Read,
        input  MDRin, MDRout, IRin, Yin, LOin, HIin, Rout, alu_op
    );

endinterface

// File: rtl/mul_div_control_sequencer_reg_select_decoder.sv
// Register-out select: a 4-bit register index plus enable becomes a one-hot
// RnOut vector, all zero when disabled.
module reg_select_decoder
    import mul_div_control_sequencer_pkg::*;
(
    input  logic [REG_IDX_W-1:0] index,
    input  logic                 en,
    output logic [NUM_REGS-1:0]  sel
);

    assign sel = en ? (NUM_REGS'(1) << index) : '0;

endmodule

// File: rtl/mul_div_control_sequencer.sv
// Hardwired fetch/decode/execute/write-back sequencer for MUL and DIV.
// Outputs are decoded from the registered state and the captured IR fields.
module mul_div_control_sequencer
    import mul_div_control_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 8
)
(
    input logic                        clock,
    input logic                        clear,
    mul_div_control_sequencer_if.master bus
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t               state;
    logic [CNT_W-1:0]     wait_cnt;
    logic [CNT_W-1:0]     wait_nxt;
    logic                 error_q;
    ir_fields_t           dec_q;
    ir_fields_t           ir_dec;

    logic                 rsel_en;
    logic [REG_IDX_W-1:0] rsel_idx;
    logic [NUM_REGS-1:0]  rout_sel;

    assign wait_nxt = wait_cnt + CNT_W'(1);
    assign ir_dec   = decode_ir(bus.ir_value);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            wait_cnt <= '0;
            error_q  <= 1'b0;
            // NOTE: the decoded-IR register is a handful of flops, so it is reset
            // like the rest of the state to keep outputs deterministic after reset.
            dec_q    <= '0;
        end else begin
            // NOTE: every register here uses <= so all of them update from the
            // same pre-edge values; a blocking = would leak new values into later lines.
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        error_q <= 1'b0;
                        state   <= T0;
                    end
                end
                T0: begin
                    wait_cnt <= '0;
                    state    <= T1;
                end
                T1: begin
                    if (bus.mem_ready) begin
                        state <= T2;
                    end else begin
                        wait_cnt <= wait_nxt;
                        // Abort before PCin ever fires, so PC keeps its old value.
                        if (wait_nxt == CNT_W'(MEM_TIMEOUT)) begin
                            error_q <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                T2:  state <= DEC;
                DEC: begin
                    dec_q <= ir_dec;
                    if (is_mul_div(ir_dec.opc)) begin
                        state <= T3;
                    end else begin
                        error_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                T3:      state <= T4;
                T4:      state <= T5;
                T5:      state <= T6;
                T6:      state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    reg_select_decoder u_reg_select (
        .index (rsel_idx),
        .en    (rsel_en),
        .sel   (rout_sel)
    );

    assign bus.Rout = rout_sel;

    always_comb begin
        // NOTE: every output gets a default before the case so no state leaves
        // one unassigned, which would otherwise infer a latch.
        bus.PCout   = 1'b0;
        bus.IncPC   = 1'b0;
        bus.MARin   = 1'b0;
        bus.Zin     = 1'b0;
        bus.Zlo_out = 1'b0;
        bus.Zhi_out = 1'b0;
        bus.PCin    = 1'b0;
        bus.Read    = 1'b0;
        bus.MDRin   = 1'b0;
        bus.MDRout  = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.LOin    = 1'b0;
        bus.HIin    = 1'b0;
        bus.alu_op  = 5'd0;
        bus.done    = 1'b0;
        rsel_en     = 1'b0;
        rsel_idx    = '0;

        case (state)
            T0: begin
                bus.PCout = 1'b1;
                bus.IncPC = 1'b1;
                bus.MARin = 1'b1;
                bus.Zin   = 1'b1;
            end
            T1: begin
                bus.Zlo_out = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                bus.PCin    = bus.mem_ready;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            T3: begin
                rsel_en  = 1'b1;
                rsel_idx = dec_q.ra;
                bus.Yin  = 1'b1;
            end
            T4: begin
                rsel_en    = 1'b1;
                rsel_idx   = dec_q.rb;
                bus.Zin    = 1'b1;
                bus.alu_op = dec_q.opc;
            end
            T5: begin
                bus.Zlo_out = 1'b1;
                bus.LOin    = 1'b1;
                bus.alu_op  = dec_q.opc;
            end
            T6: begin
                bus.Zhi_out = 1'b1;
                bus.HIin    = 1'b1;
                bus.alu_op  = dec_q.opc;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase

        bus.busy  = (state != IDLE);
        bus.error = error_q;
    end

endmodule

// File: tb/tb_mul_div_control_sequencer.sv
// Bench for mul_div_control_sequencer: a small DataPath/memory model reacts to the
// strobes, and a scoreboard compares each finished instruction with arithmetic expectations.
module tb_mul_div_control_sequencer;
    import mul_div_control_sequencer_pkg::*;

    localparam int MEM_TIMEOUT = 8;

    logic clock = 1'b0;
    logic clear = 1'b0;
    always #5 clock = ~clock;

    mul_div_control_sequencer_if s ();

    mul_div_control_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (s)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- DataPath and memory environment ----------------
    logic [31:0] regs [16];
    logic [31:0] mem  [256];
    logic [31:0] pc = '0, mar = '0, mdr = '0, ir = '0, y = '0;
    logic [31:0] zlo = '0, zhi = '0, lo = '0, hi = '0;
    logic [31:0] dbus;
    int          rd_cnt = 0;
    int          cur_wait = 0;

    always_comb begin
        dbus = '0;
        if (s.PCout)   dbus = pc;
        if (s.Zlo_out) dbus = zlo;
        if (s.Zhi_out) dbus = zhi;
        if (s.MDRout)  dbus = mdr;
        for (int i = 0; i < 16; i++) if (s.Rout[i]) dbus = regs[i];
    end

    assign s.ir_value  = ir;
    assign s.mem_ready = s.Read && (rd_cnt >= cur_wait);

    always @(posedge clock) begin
        rd_cnt <= s.Read ? rd_cnt + 1 : 0;
        if (s.MARin) mar <= dbus;
        if (s.Zin) begin
            case (s.alu_op)
                OP_MUL:  {zhi, zlo} <= 64'(y) * 64'(dbus);
                OP_DIV: begin
                    zlo <= (dbus != 0) ? y / dbus : 32'd0;
                    zhi <= (dbus != 0) ? y % dbus : 32'd0;
                end
                default: if (s.IncPC) begin
                    zlo <= dbus + 32'd1;
                    zhi <= 32'd0;
                end
            endcase
        end
        if (s.PCin) pc <= dbus;
        if (s.Read && s.MDRin && s.mem_ready) mdr <= mem[mar[7:0]];
        if (s.IRin) ir <= dbus;
        if (s.Yin)  y  <= dbus;
        if (s.LOin) lo <= dbus;
        if (s.HIin) hi <= dbus;
    end

    // ---------------- Reference model and scoreboard ----------------
    typedef struct {
        int          end_cyc;
        logic        done;
        logic        err;
        logic [31:0] pc;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [4:0]  opc;
        int          pcin_n;
        int          wb_n;
        int          alu_n;
    } exp_t;

    exp_t        q [$];
    logic [31:0] ref_pc = '0, ref_lo = '0, ref_hi = '0;
    bit          sb_en = 1'b0;

    function automatic logic [37:0] out_vec();
        return {s.busy, s.done, s.error, s.PCout, s.IncPC, s.MARin, s.Zin, s.Zlo_out,
                s.Zhi_out, s.PCin, s.Read, s.MDRin, s.MDRout, s.IRin, s.Yin, s.LOin,
                s.HIin, s.Rout, s.alu_op};
    endfunction

    task automatic issue(input logic [4:0] opc, input logic [3:0] ra, input logic [3:0] rb,
                         input int w, input bit extra);
        exp_t        e;
        logic [63:0] prod;
        logic [31:0] a, b;
        int          c, k;
        bit          legal, tmo;
        a = regs[ra];
        b = regs[rb];
        mem[ref_pc[7:0]] = {opc, 4'($urandom), ra, rb, 15'($urandom)};
        cur_wait = w;
        legal = (opc == OP_MUL) || (opc == OP_DIV);
        tmo   = (w >= MEM_TIMEOUT);
        @(posedge clock); #1;
        c = cyc;
        e.opc = opc;
        e.pcin_n = 0; e.wb_n = 0; e.alu_n = 0;
        if (tmo) begin
            e.end_cyc = c + 2 + MEM_TIMEOUT;
            e.done = 1'b0;
            e.err  = 1'b1;
        end else begin
            ref_pc   = ref_pc + 1;
            e.done   = 1'b1;
            e.pcin_n = 1;
            if (legal) begin
                if (opc == OP_MUL) begin
                    prod   = 64'(a) * 64'(b);
                    ref_lo = prod[31:0];
                    ref_hi = prod[63:32];
                end else begin
                    ref_lo = a / b;
                    ref_hi = a % b;
                end
                e.err     = 1'b0;
                e.wb_n    = 3;
                e.alu_n   = 3;
                e.end_cyc = c + 9 + w;
            end else begin
                e.err     = 1'b1;
                e.end_cyc = c + 5 + w;
            end
        end
        e.pc = ref_pc; e.lo = ref_lo; e.hi = ref_hi;
        q.push_back(e);
        s.start = 1'b1;
        @(posedge clock); #1;
        s.start = 1'b0;
        if (extra) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
            s.start = 1'b1;
            @(posedge clock); #1;
            s.start = 1'b0;
        end
        k = 0;
        while (s.busy && k < 60) begin @(negedge clock); k++; end
        check("busy_bound", 64'(s.busy), 64'(0));
    endtask

    int n_pcin = 0, n_wb = 0, n_alu = 0, n_alubad = 0;
    bit saw_done = 1'b0, prev_busy = 1'b0;

    always @(negedge clock) begin
        if (clear && sb_en) begin
            check("bus_drivers", 64'(int'(s.PCout) + int'(s.Zlo_out) + int'(s.Zhi_out)
                  + int'(s.MDRout) + $countones(s.Rout) <= 1), 64'(1));
            n_pcin <= n_pcin + int'(s.PCin);
            n_wb   <= n_wb + int'(s.Yin) + int'(s.LOin) + int'(s.HIin);
            n_alu  <= n_alu + int'(s.alu_op != 5'd0);
            if (q.size() != 0 && s.alu_op != 5'd0 && s.alu_op != q[0].opc)
                n_alubad <= n_alubad + 1;
            if (s.done || (prev_busy && !s.busy && !saw_done)) begin
                if (q.size() == 0) begin
                    check("pending_txn", 64'(q.size()), 64'(1));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("end_cycle",   64'(cyc),      64'(e.end_cyc));
                    check("done_pulse",  64'(s.done),   64'(e.done));
                    check("error_flag",  64'(s.error),  64'(e.err));
                    check("pc_value",    64'(pc),       64'(e.pc));
                    check("lo_value",    64'(lo),       64'(e.lo));
                    check("hi_value",    64'(hi),       64'(e.hi));
                    check("pcin_count",  64'(n_pcin),   64'(e.pcin_n));
                    check("y_lo_hi_cnt", 64'(n_wb),     64'(e.wb_n));
                    check("alu_cycles",  64'(n_alu),    64'(e.alu_n));
                    check("alu_op_val",  64'(n_alubad), 64'(0));
                end
                n_pcin <= 0; n_wb <= 0; n_alu <= 0; n_alubad <= 0;
            end
            saw_done <= s.done ? 1'b1 : (s.busy ? saw_done : 1'b0);
        end
        prev_busy <= s.busy;
    end

    // ---------------- Stimulus ----------------
    initial begin
        int          k;
        logic [4:0]  opc;
        logic [3:0]  ra, rb;
        int          w, r;
        s.start = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = $urandom | 32'd1;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        regs[4] = 32'd20;
        regs[5] = 32'd5;

        repeat (2) @(negedge clock);
        check("reset_outputs", 64'(out_vec()), 64'(0));
        @(posedge clock); #1;
        clear = 1'b1;
        sb_en = 1'b1;

        issue(OP_MUL, 4'd4, 4'd5, 0, 1'b0);
        issue(OP_DIV, 4'd4, 4'd5, 0, 1'b0);
        issue(OP_MUL, 4'd4, 4'd5, 3, 1'b0);
        issue(OP_DIV, 4'd4, 4'd5, 20, 1'b0);
        @(negedge clock);
        check("error_sticky", 64'(s.error), 64'(1));
        issue(OP_MUL, 4'd5, 4'd4, 0, 1'b0);
        issue(5'b00001, 4'd4, 4'd5, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            r   = int'($urandom_range(0, 9));
            opc = (r < 4) ? OP_MUL : (r < 8) ? OP_DIV : 5'($urandom);
            w   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, MEM_TIMEOUT + 2))
                                               : int'($urandom_range(0, 2));
            ra  = 4'($urandom);
            rb  = 4'($urandom);
            regs[ra] = $urandom | 32'd1;
            regs[rb] = $urandom | 32'd1;
            issue(opc, ra, rb, w, 1'($urandom));
        end

        // Reset in the middle of T4 must abort with no write-back.
        sb_en = 1'b0;
        mem[ref_pc[7:0]] = {OP_MUL, 4'd0, 4'd4, 4'd5, 15'd0};
        cur_wait = 0;
        @(posedge clock); #1;
        s.start = 1'b1;
        @(posedge clock); #1;
        s.start = 1'b0;
        k = 0;
        while (!(s.Zin && s.alu_op == OP_MUL) && k < 30) begin @(negedge clock); k++; end
        check("reach_t4", 64'(s.alu_op), 64'(OP_MUL));
        #1 clear = 1'b0;
        #1 check("reset_mid_t4", 64'(out_vec()), 64'(0));
        @(posedge clock); #1;
        check("no_wb_lo", 64'(lo), 64'(ref_lo));
        check("no_wb_hi", 64'(hi), 64'(ref_hi));
        clear = 1'b1;
        @(negedge clock);
        check("idle_after_reset", 64'(s.busy), 64'(0));
        ref_pc = ref_pc + 1;
        sb_en = 1'b1;
        issue(OP_DIV, 4'd4, 4'd5, 1, 1'b1);

        repeat (2) @(posedge clock);
        check("queue_empty", 64'(q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
